// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the system bus arbiter.
// Grant and strobe signals are active low, hence the ENABLE_/DISABLE_ levels.
package bus_arbiter_pkg;

  localparam int unsigned TENURE_W = 8;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Conventional master slots on the system bus
  localparam int unsigned MST_IF  = 0;
  localparam int unsigned MST_MEM = 1;
  localparam int unsigned MST_DMA = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req_c strictly after ptr, wrapping.
module bus_arbiter_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid_c,
  output logic [W-1:0] idx_c
);

  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!valid_c && req[W'((32'(ptr) + i) % N)]) begin
        valid_c = 1'b1;
        idx_c   = W'((32'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with active-low grants and an optional
// tenure limit that rotates ownership only between transactions.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned OWNER_W     = 2,
  parameter int unsigned MAX_TENURE  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req_,
  input  logic [NUM_MASTERS-1:0] m_as_,
  input  logic                   bus_rdy_,
  output logic [NUM_MASTERS-1:0] m_grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   bus_busy
);

  state_e                 state_q, state_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d;
  logic [OWNER_W-1:0]     owner_d;
  logic [NUM_MASTERS-1:0] grnt_d;
  logic                   busy_d;
  logic                   inflight_q, inflight_d;
  logic [TENURE_W-1:0]    tenure_q, tenure_d;

  logic [NUM_MASTERS-1:0] pick_req;
  logic                   pick_valid;
  logic [OWNER_W-1:0]     pick_idx;

  logic own_req, own_as, rdy, lock, release_own, preempt, grant_new;

  // The current owner never competes in its own hand-over search
  always_comb begin
    pick_req = ~m_req_;
    if (state_q == ST_GRANT) pick_req[owner] = 1'b0;
  end

  bus_arbiter_rr_pick #(
    .N (NUM_MASTERS),
    .W (OWNER_W)
  ) u_pick (
    .req     (pick_req),
    .ptr     (ptr_q),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  assign own_req = ~m_req_[owner];
  assign own_as  = ~m_as_[owner];
  assign rdy     = ~bus_rdy_;
  // A transaction being started or in flight pins the current owner
  assign lock    = inflight_q | own_as;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner;
    grnt_d      = m_grnt_;
    busy_d      = bus_busy;
    inflight_d  = inflight_q;
    tenure_d    = tenure_q;
    release_own = 1'b0;
    preempt     = 1'b0;
    grant_new   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) grant_new = 1'b1;
      end
      ST_GRANT: begin
        if (rdy)         inflight_d = 1'b0;
        else if (own_as) inflight_d = 1'b1;

        if (rdy && (tenure_q != TENURE_W'(MAX_TENURE))) tenure_d = tenure_q + TENURE_W'(1);

        release_own = !own_req && !lock;
        preempt     = (MAX_TENURE != 0) && (tenure_q == TENURE_W'(MAX_TENURE))
                      && pick_valid && !lock;

        if (release_own || preempt) begin
          if (pick_valid) begin
            grant_new = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            grnt_d   = {NUM_MASTERS{DISABLE_}};
            busy_d   = 1'b0;
            tenure_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_new) begin
      state_d          = ST_GRANT;
      owner_d          = pick_idx;
      ptr_d            = pick_idx;
      grnt_d           = {NUM_MASTERS{DISABLE_}};
      grnt_d[pick_idx] = ENABLE_;
      busy_d           = 1'b1;
      tenure_d         = '0;
      inflight_d       = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= OWNER_W'(NUM_MASTERS - 1);
      owner      <= '0;
      m_grnt_    <= {NUM_MASTERS{DISABLE_}};
      bus_busy   <= 1'b0;
      inflight_q <= 1'b0;
      tenure_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner      <= owner_d;
      m_grnt_    <= grnt_d;
      bus_busy   <= busy_d;
      inflight_q <= inflight_d;
      tenure_q   <= tenure_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with a tenure limit of two.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] m_req_;
  logic [3:0] m_as_;
  logic       bus_rdy_;
  logic [3:0] m_grnt_;
  logic [1:0] owner;
  logic       bus_busy;

  int n_cmp;
  int n_err;

  bus_arbiter #(
    .NUM_MASTERS (4),
    .OWNER_W     (2),
    .MAX_TENURE  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req_   (m_req_),
    .m_as_    (m_as_),
    .bus_rdy_ (bus_rdy_),
    .m_grnt_  (m_grnt_),
    .owner    (owner),
    .bus_busy (bus_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                     input logic eb);
    n_cmp++;
    assert (m_grnt_ === eg) else begin
      n_err++;
      $error("FAIL %s m_grnt_ got %b expected %b", tag, m_grnt_, eg);
    end
    n_cmp++;
    assert (owner === eo) else begin
      n_err++;
      $error("FAIL %s owner got %0d expected %0d", tag, owner, eo);
    end
    n_cmp++;
    assert (bus_busy === eb) else begin
      n_err++;
      $error("FAIL %s bus_busy got %b expected %b", tag, bus_busy, eb);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    m_req_   = 4'b1111;
    m_as_    = 4'b1111;
    bus_rdy_ = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    n_cmp = 0;
    n_err = 0;

    // Reset state
    do_reset();
    step();
    chk("reset", 4'b1111, 2'd0, 1'b0);
    step();
    chk("idle_no_req", 4'b1111, 2'd0, 1'b0);

    // Single request, hold, then release to idle
    m_req_ = 4'b1110;
    step();
    chk("single_grant", 4'b1110, 2'(MST_IF), 1'b1);
    step(); step();
    chk("single_hold", 4'b1110, 2'd0, 1'b1);
    m_req_ = 4'b1111;
    step();
    chk("single_release", 4'b1111, 2'd0, 1'b0);

    // Round-robin 0,1,2,3,0 with one transaction each and no dead cycle
    do_reset();
    m_req_ = 4'b0000;
    step();
    chk("rr_first", 4'b1110, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      g = 4'b1111;
      g[i] = 1'b0;
      m_as_[i] = 1'b0;
      step();
      chk("rr_as_hold", g, 2'(i), 1'b1);
      m_as_ = 4'b1111;
      bus_rdy_ = 1'b0;
      step();
      chk("rr_rdy_hold", g, 2'(i), 1'b1);
      bus_rdy_ = 1'b1;
      m_req_[i] = 1'b1;
      step();
      g = 4'b1111;
      g[(i + 1) % 4] = 1'b0;
      chk("rr_handover", g, 2'((i + 1) % 4), 1'b1);
      m_req_[i] = 1'b0;
    end

    // Tenure preemption after two completed transactions
    do_reset();
    m_req_ = 4'b1010;
    step();
    chk("ten_grant0", 4'b1110, 2'd0, 1'b1);
    m_as_ = 4'b1110;
    step();
    m_as_ = 4'b1111; bus_rdy_ = 1'b0;
    step();
    chk("ten_txn1", 4'b1110, 2'd0, 1'b1);
    m_as_ = 4'b1110; bus_rdy_ = 1'b1;
    step();
    m_as_ = 4'b1111; bus_rdy_ = 1'b0;
    step();
    chk("ten_limit_reached", 4'b1110, 2'd0, 1'b1);
    bus_rdy_ = 1'b1;
    step();
    chk("ten_preempt", 4'b1011, 2'(MST_DMA), 1'b1);
    m_req_ = 4'b1110;
    step();
    chk("ten_back_to_0", 4'b1110, 2'd0, 1'b1);

    // No preemption while a transaction is in flight
    do_reset();
    m_req_ = 4'b1010;
    step();
    m_as_ = 4'b1110; bus_rdy_ = 1'b0;
    step(); step();
    chk("infl_limit", 4'b1110, 2'd0, 1'b1);
    bus_rdy_ = 1'b1;
    step();
    chk("infl_as_k", 4'b1110, 2'd0, 1'b1);
    m_as_ = 4'b1111;
    step(); step(); step();
    chk("infl_wait", 4'b1110, 2'd0, 1'b1);
    bus_rdy_ = 1'b0;
    step();
    chk("infl_rdy_k4", 4'b1110, 2'd0, 1'b1);
    bus_rdy_ = 1'b1;
    step();
    chk("infl_move_k6", 4'b1011, 2'd2, 1'b1);

    // Request dropped mid-transaction keeps the grant until ready
    do_reset();
    m_req_ = 4'b0110;
    step();
    chk("drop_grant0", 4'b1110, 2'd0, 1'b1);
    m_as_ = 4'b1110;
    step();
    m_as_ = 4'b1111; m_req_ = 4'b0111;
    step();
    chk("drop_held1", 4'b1110, 2'd0, 1'b1);
    step();
    chk("drop_held2", 4'b1110, 2'd0, 1'b1);
    bus_rdy_ = 1'b0;
    step();
    chk("drop_rdy", 4'b1110, 2'd0, 1'b1);
    bus_rdy_ = 1'b1;
    step();
    chk("drop_next", 4'b0111, 2'd3, 1'b1);

    // Reset while master 3 owns; first arbitration afterwards picks 1
    reset = 1'b1;
    m_req_ = 4'b0101;
    step();
    chk("midreset", 4'b1111, 2'd0, 1'b0);
    reset = 1'b0;
    step();
    chk("post_reset_pick", 4'b1101, 2'(MST_MEM), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
